// File: rtl/sd_resp_pkg.sv
// Shared definitions for the SD command-line response path: response type
// codes, frame geometry, field bit positions (wire order, bit 0 = start bit),
// the CRC7 polynomial and the checker state encoding.
package sd_resp_pkg;

    // Response type codes as presented on resp_type
    localparam logic [1:0] RESP_R1 = 2'b00;
    localparam logic [1:0] RESP_R2 = 2'b01;
    localparam logic [1:0] RESP_R3 = 2'b10;

    // Frame lengths on the wire
    localparam int unsigned FRAME_LEN_SHORT = 48;
    localparam int unsigned FRAME_LEN_LONG  = 136;

    // Header fields
    localparam int unsigned BIT_START = 0;
    localparam int unsigned BIT_TRANS = 1;
    localparam int unsigned INDEX_LO  = 2;
    localparam int unsigned INDEX_HI  = 7;
    localparam int unsigned INDEX_W   = INDEX_HI - INDEX_LO + 1;

    // CRC7 fields and coverage
    localparam int unsigned CRC_W        = 7;
    localparam int unsigned R1_CRC_LO    = 40;
    localparam int unsigned R2_CRC_LO    = 128;
    localparam int unsigned R1_CRC_START = 0;
    localparam int unsigned R1_CRC_N     = 40;
    localparam int unsigned R2_CRC_START = 8;
    localparam int unsigned R2_CRC_N     = 120;
    localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

    // End bits
    localparam int unsigned R1_END = FRAME_LEN_SHORT - 1;
    localparam int unsigned R2_END = FRAME_LEN_LONG - 1;

    // Payload extraction
    localparam int unsigned PAYLOAD_LO      = 8;
    localparam int unsigned PAYLOAD_W       = 120;
    localparam int unsigned SHORT_PAYLOAD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CRC   = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Per-field error flags reported with each result
    typedef struct packed {
        logic start;
        logic trans;
        logic index;
        logic crc;
        logic end_bit;
        logic overrun;
    } resp_err_t;

endpackage

// File: rtl/crc7_serial.sv
// Serial CRC7 (x^7 + x^3 + 1), one message bit per enabled clock, MSB-first.
// Ports: clk, reset (async, active-high), clear (sync zero), bit_en (consume
// bit_in this clock), bit_in (message bit), crc (current remainder).
module crc7_serial
    import sd_resp_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             bit_en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;
    logic             fb_c;

    // Next remainder: shift left, fold in polynomial when feedback is set
    always_comb begin
        fb_c  = bit_in ^ crc_q[CRC_W-1];
        crc_d = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (bit_en) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb_c ? CRC7_POLY : '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_resp_checker.sv
// Captures a completed CMD-line response frame, runs CRC7 over the covered
// bits, then checks framing/index/CRC fields and presents payload and error
// flags with a one-cycle done strobe.
// Ports: clk, reset (async, active-high); frame_in/frame_valid from the
// deserializer (rising edge of frame_valid captures); resp_type and
// expected_index sampled at capture; busy, done, ok, err_* and payload are
// registered results, held until the next check completes.
module sd_resp_checker
    import sd_resp_pkg::*;
#(
    parameter int unsigned BITS  = FRAME_LEN_LONG,
    parameter int unsigned CNT_W = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BITS-1:0]      frame_in,
    input  logic                 frame_valid,
    input  logic [1:0]           resp_type,
    input  logic [INDEX_W-1:0]   expected_index,
    output logic                 busy,
    output logic                 done,
    output logic                 ok,
    output logic                 err_start,
    output logic                 err_trans,
    output logic                 err_index,
    output logic                 err_crc,
    output logic                 err_end,
    output logic                 err_overrun,
    output logic [PAYLOAD_W-1:0] payload
);

    localparam int unsigned IDX_W = $clog2(BITS);

    state_t state_q, state_d;

    logic                       fv_q;
    logic [BITS-1:0]            frame_q, frame_d;
    logic [1:0]                 type_q, type_d;
    logic [INDEX_W-1:0]         exp_idx_q, exp_idx_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       ovr_q, ovr_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       ok_q, ok_d;
    resp_err_t                  err_q, err_d;
    logic [PAYLOAD_W-1:0]       payload_q, payload_d;

    logic                       rise_c;
    logic                       capture_c;
    logic                       is_r2_c;
    logic                       is_r3_c;
    logic [CNT_W-1:0]           crc_n_c;
    logic                       crc_last_c;
    logic                       crc_en_c;
    logic [IDX_W-1:0]           bit_idx_c;
    logic                       crc_bit_c;
    logic [CRC_W-1:0]           crc_c;
    logic [CRC_W-1:0]           crc_rx_c;
    logic [INDEX_W-1:0]         idx_rx_c;
    logic [PAYLOAD_W-1:0]       long_pl_c;
    logic [SHORT_PAYLOAD_W-1:0] short_pl_c;

    // Frame decode and CRC sequencing helpers
    always_comb begin
        rise_c     = frame_valid & ~fv_q;
        capture_c  = (state_q == ST_IDLE) && rise_c;
        is_r2_c    = (type_q == RESP_R2);
        is_r3_c    = (type_q == RESP_R3);
        crc_n_c    = is_r2_c ? CNT_W'(R2_CRC_N) : (is_r3_c ? '0 : CNT_W'(R1_CRC_N));
        crc_last_c = (cnt_q == crc_n_c);
        crc_en_c   = (state_q == ST_CRC) && !crc_last_c;
        bit_idx_c  = IDX_W'(cnt_q) + (is_r2_c ? IDX_W'(R2_CRC_START) : IDX_W'(R1_CRC_START));
        crc_bit_c  = frame_q[bit_idx_c];
        // Wire order puts the field MSB at the lowest frame index, hence the reversals
        idx_rx_c   = {<<{frame_q[INDEX_HI:INDEX_LO]}};
        crc_rx_c   = is_r2_c ? {<<{frame_q[R2_CRC_LO+CRC_W-1:R2_CRC_LO]}}
                             : {<<{frame_q[R1_CRC_LO+CRC_W-1:R1_CRC_LO]}};
        long_pl_c  = {<<{frame_q[PAYLOAD_LO+PAYLOAD_W-1:PAYLOAD_LO]}};
        short_pl_c = {<<{frame_q[PAYLOAD_LO+SHORT_PAYLOAD_W-1:PAYLOAD_LO]}};
    end

    crc7_serial u_crc (
        .clk    (clk),
        .reset  (reset),
        .clear  (capture_c),
        .bit_en (crc_en_c),
        .bit_in (crc_bit_c),
        .crc    (crc_c)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: CRC state lasts N+1 cycles (last one only detects completion)
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (rise_c) state_d = ST_CRC;
            ST_CRC:   if (crc_last_c) state_d = ST_CHECK;
            ST_CHECK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        frame_d   = frame_q;
        type_d    = type_q;
        exp_idx_d = exp_idx_q;
        cnt_d     = cnt_q;
        ovr_d     = ovr_q;
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_q == ST_CHECK);
        ok_d      = ok_q;
        err_d     = err_q;
        payload_d = payload_q;

        if (capture_c) begin
            frame_d   = frame_in;
            type_d    = (resp_type == RESP_R2 || resp_type == RESP_R3) ? resp_type : RESP_R1;
            exp_idx_d = expected_index;
            cnt_d     = '0;
        end else if (crc_en_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (state_q == ST_CHECK) begin
            err_d.start   = frame_q[BIT_START];
            err_d.trans   = frame_q[BIT_TRANS];
            err_d.index   = !is_r2_c && !is_r3_c && (idx_rx_c != exp_idx_q);
            err_d.crc     = !is_r3_c && (crc_c != crc_rx_c);
            err_d.end_bit = is_r2_c ? ~frame_q[R2_END] : ~frame_q[R1_END];
            err_d.overrun = ovr_q;
            ok_d          = ~|err_d;
            payload_d     = is_r2_c ? long_pl_c : PAYLOAD_W'(short_pl_c);
            // An edge coinciding with the reporting cycle belongs to the next result
            ovr_d         = rise_c;
        end else if (state_q != ST_IDLE && rise_c) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fv_q      <= 1'b0;
            frame_q   <= '0;
            type_q    <= '0;
            exp_idx_q <= '0;
            cnt_q     <= '0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= '0;
            payload_q <= '0;
        end else begin
            fv_q      <= frame_valid;
            frame_q   <= frame_d;
            type_q    <= type_d;
            exp_idx_q <= exp_idx_d;
            cnt_q     <= cnt_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            payload_q <= payload_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign ok          = ok_q;
    assign err_start   = err_q.start;
    assign err_trans   = err_q.trans;
    assign err_index   = err_q.index;
    assign err_crc     = err_q.crc;
    assign err_end     = err_q.end_bit;
    assign err_overrun = err_q.overrun;
    assign payload     = payload_q;

endmodule

// File: tb/tb_sd_resp_checker.sv
// Randomized self-checking bench for sd_resp_checker against a behavioural
// model (CRC7 by polynomial long division, fields by wire-order extraction).
module tb_sd_resp_checker;

    logic         clk = 1'b0;
    logic         reset;
    logic [135:0] frame_in;
    logic         frame_valid;
    logic [1:0]   resp_type;
    logic [5:0]   expected_index;
    logic         busy, done, ok;
    logic         err_start, err_trans, err_index, err_crc, err_end, err_overrun;
    logic [119:0] payload;

    int checks   = 0;
    int failures = 0;
    logic prev_ok = 1'b0;

    typedef struct {
        logic [5:0]   flags;
        logic         ok;
        logic [119:0] pl;
        int           lat;
    } exp_t;

    sd_resp_checker dut (
        .clk            (clk),
        .reset          (reset),
        .frame_in       (frame_in),
        .frame_valid    (frame_valid),
        .resp_type      (resp_type),
        .expected_index (expected_index),
        .busy           (busy),
        .done           (done),
        .ok             (ok),
        .err_start      (err_start),
        .err_trans      (err_trans),
        .err_index      (err_index),
        .err_crc        (err_crc),
        .err_end        (err_end),
        .err_overrun    (err_overrun),
        .payload        (payload)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Place a w-bit value on the wire starting at pos, MSB first
    function automatic logic [135:0] put(input logic [135:0] f, input int pos,
                                         input logic [127:0] v, input int w);
        logic [135:0] r;
        r = f;
        for (int k = 0; k < w; k++) r[pos+k] = v[w-1-k];
        return r;
    endfunction

    // Read a w-bit wire-order field starting at pos (first bit = MSB)
    function automatic logic [127:0] field(input logic [135:0] f, input int pos, input int w);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < w; k++) v = {v[126:0], f[pos+k]};
        return v;
    endfunction

    // Remainder of M(x)*x^7 divided by x^7+x^3+1
    function automatic logic [6:0] crc_div(input logic [135:0] f, input int lo, input int n);
        logic       a [0:127];
        logic [7:0] g;
        logic [6:0] r;
        g = 8'b1000_1001;
        r = '0;
        for (int i = 0; i < 128; i++) a[i] = 1'b0;
        for (int i = 0; i < n; i++) a[i] = f[lo+i];
        for (int i = 0; i < n; i++)
            if (a[i]) for (int j = 0; j < 8; j++) a[i+j] = a[i+j] ^ g[7-j];
        for (int k = 0; k < 7; k++) r = {r[5:0], a[n+k]};
        return r;
    endfunction

    function automatic exp_t model(input logic [135:0] f, input logic [1:0] t,
                                   input logic [5:0] ei, input logic ov);
        exp_t e;
        logic r2, r3, s, tr, ix, c, en;
        r2 = (t == 2'b01);
        r3 = (t == 2'b10);
        s  = f[0];
        tr = f[1];
        ix = !r2 && !r3 && (6'(field(f, 2, 6)) != ei);
        if (r3)      c = 1'b0;
        else if (r2) c = crc_div(f, 8, 120) != 7'(field(f, 128, 7));
        else         c = crc_div(f, 0, 40) != 7'(field(f, 40, 7));
        en = r2 ? ~f[135] : ~f[47];
        e.flags = {s, tr, ix, c, en, ov};
        e.ok    = (e.flags == 6'b0);
        e.pl    = r2 ? 120'(field(f, 8, 120)) : 120'(field(f, 8, 32));
        e.lat   = (r2 ? 120 : (r3 ? 0 : 40)) + 2;
        return e;
    endfunction

    function automatic logic [135:0] mk_r1(input logic [39:0] b, input logic endb);
        logic [135:0] f;
        f = put('0, 0, 128'(b), 40);
        f = put(f, 40, 128'(crc_div(f, 0, 40)), 7);
        f[47] = endb;
        return f;
    endfunction

    function automatic logic [135:0] mk_r2(input logic [119:0] p, input logic inv);
        logic [135:0] f;
        logic [6:0]   c;
        f = put('0, 0, 128'(8'h3F), 8);
        f = put(f, 8, 128'(p), 120);
        c = crc_div(f, 8, 120);
        if (inv) c = ~c;
        f = put(f, 128, 128'(c), 7);
        f[135] = 1'b1;
        return f;
    endfunction

    function automatic logic [119:0] rnd120();
        return 120'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    // Drive a frame (caller ensures frame_valid was low at the previous edge),
    // scramble inputs while busy, optionally inject a second edge, then check
    // latency and results. Returns on the negedge where done is seen.
    task automatic run_frame(input string nm, input logic [135:0] f, input logic [1:0] t,
                             input logic [5:0] ei, input int ovr_at);
        exp_t e;
        int   cyc;
        bit   seen;
        e = model(f, t, ei, ovr_at > 0);
        frame_in       = f;
        resp_type      = t;
        expected_index = ei;
        frame_valid    = 1'b1;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1;
            end else begin
                if (cyc == 1) begin
                    check({nm, ".busy"}, 128'(busy), 128'(1));
                    check({nm, ".hold_ok"}, 128'(ok), 128'(prev_ok));
                    frame_valid    = 1'b0;
                    frame_in       = {8'($urandom), 120'(rnd120())} ^ f;
                    resp_type      = 2'($urandom);
                    expected_index = 6'($urandom);
                end
                if (ovr_at > 0 && cyc == ovr_at)     frame_valid = 1'b1;
                if (ovr_at > 0 && cyc == ovr_at + 1) frame_valid = 1'b0;
            end
        end
        check({nm, ".latency"}, 128'(cyc - 1), 128'(e.lat));
        check({nm, ".busy_end"}, 128'(busy), 128'(0));
        check({nm, ".flags"}, 128'({err_start, err_trans, err_index, err_crc, err_end, err_overrun}),
              128'(e.flags));
        check({nm, ".ok"}, 128'(ok), 128'(e.ok));
        check({nm, ".payload"}, 128'(payload), 128'(e.pl));
        prev_ok = e.ok;
    endtask

    // Count done pulses over n idle cycles; none are expected
    task automatic quiet(input string nm, input int n);
        int dn;
        dn = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        check({nm, ".quiet"}, 128'(dn), 128'(0));
    endtask

    function automatic logic [135:0] mk_rand(input logic [1:0] t);
        logic [39:0] b;
        b = {2'b00, 6'($urandom), 32'($urandom)};
        if (t == 2'b01) return mk_r2(rnd120(), 1'b0);
        if (t == 2'b10) return put(put('0, 0, 128'(b), 40), 40, 128'({7'($urandom), 1'b1}), 8);
        return mk_r1(b, 1'b1);
    endfunction

    initial begin
        logic [135:0] f;
        logic [1:0]   t;
        logic [5:0]   ei;
        int           cyc;
        int           bc;

        reset = 1'b1;
        frame_valid = 1'b0;
        frame_in = '0;
        resp_type = '0;
        expected_index = '0;
        repeat (2) @(negedge clk);
        check("reset.busy_done", 128'({busy, done}), 128'(0));
        check("reset.ok_flags", 128'({ok, err_start, err_trans, err_index, err_crc, err_end, err_overrun}), 128'(0));
        check("reset.payload", 128'(payload), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        // R1 good, then single-cycle done
        f = mk_r1(40'h11_0000_0900, 1'b1);
        run_frame("r1_good", f, 2'b00, 6'd17, 0);
        check("r1_good.pl_const", 128'(payload), 128'(32'h0000_0900));
        @(negedge clk);
        check("r1_good.done_width", 128'(done), 128'(0));

        // CRC corruption and index mismatch
        f[20] = ~f[20];
        run_frame("r1_crc", f, 2'b00, 6'd17, 0);
        f[20] = ~f[20];
        run_frame("r1_idx", f, 2'b00, 6'd18, 0);

        // Transmission and end bit errors
        f = mk_r1(40'h40_0000_0000, 1'b1);
        run_frame("r1_trans", f, 2'b00, 6'd0, 0);
        f[47] = 1'b0;
        run_frame("r1_trans_end", f, 2'b00, 6'd0, 0);

        // R3: no CRC, no index check
        f = put(put('0, 0, 128'(40'h3F_80FF_8000), 40), 40, 128'(8'hFF), 8);
        run_frame("r3", f, 2'b10, 6'd5, 0);
        check("r3.pl_const", 128'(payload), 128'(32'h80FF_8000));

        // R2 round trip and inverted CRC
        f = mk_r2(rnd120(), 1'b0);
        run_frame("r2_good", f, 2'b01, 6'd0, 0);
        f = mk_r2(rnd120(), 1'b1);
        run_frame("r2_badcrc", f, 2'b01, 6'd0, 0);

        // Type 11 behaves as R1
        f = mk_rand(2'b00);
        run_frame("t11", f, 2'b11, 6'(field(f, 2, 6)), 0);

        // Randomized back-to-back frames with optional corruption
        for (int i = 0; i < 16; i++) begin
            t  = 2'($urandom);
            f  = mk_rand(t);
            if ($urandom_range(0, 1) == 1)
                f[$urandom_range(0, (t == 2'b01) ? 135 : 47)] ^= 1'b1;
            ei = ($urandom_range(0, 1) == 1) ? 6'(field(f, 2, 6)) : 6'($urandom);
            run_frame($sformatf("rnd%0d", i), f, t, ei, 0);
        end

        // Overrun: reported once, then cleared
        f = mk_r1(40'h11_0000_0900, 1'b1);
        run_frame("ovr", f, 2'b00, 6'd17, 10);
        quiet("ovr", 5);
        run_frame("ovr_next", f, 2'b00, 6'd17, 0);
        quiet("post", 3);

        // A held frame_valid level captures exactly once
        f = put(put('0, 0, 128'(40'h3F_80FF_8000), 40), 40, 128'(8'hFF), 8);
        frame_in = f;
        resp_type = 2'b10;
        frame_valid = 1'b1;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("level.latency", 128'(cyc - 1), 128'(2));
        bc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy || done) bc++;
        end
        check("level.no_retrigger", 128'(bc), 128'(0));
        frame_valid = 1'b0;
        @(negedge clk);

        // Reset mid-check aborts without done
        frame_in = mk_r1(40'h11_0000_0900, 1'b1);
        resp_type = 2'b00;
        expected_index = 6'd17;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid.busy_done", 128'({busy, done}), 128'(0));
        check("rst_mid.ok_flags", 128'({ok, err_start, err_trans, err_index, err_crc, err_end, err_overrun}), 128'(0));
        check("rst_mid.payload", 128'(payload), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        quiet("rst_mid", 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
